// File: rtl/ofs_fim_pcie_pkg.sv
// Shared types and helpers for the PCIe HIP control-shadow tracker.
package ofs_fim_pcie_pkg;

    localparam int CFG_W            = 7;
    localparam int CFG_ATS_EN_BIT   = 6;
    localparam int CFG_TPH_EN_BIT   = 5;
    localparam int CFG_TPH_ST_LSB   = 3;
    localparam int CFG_MSIX_EN_BIT  = 2;
    localparam int CFG_MSIX_MSK_BIT = 1;
    localparam int CFG_BME_BIT      = 0;

    typedef struct packed {
        logic       ats_en;
        logic       tph_en;
        logic [1:0] tph_st;
        logic       msix_en;
        logic       msix_mask;
        logic       bme;
    } t_ctl_shdw_cfg;

    typedef enum logic [1:0] {
        SCAN_ST_REQ  = 2'd0,
        SCAN_ST_SCAN = 2'd1,
        SCAN_ST_DONE = 2'd2
    } t_scan_state;

    function automatic logic [CFG_W-1:0] cfg_to_bits(input t_ctl_shdw_cfg c);
        logic [CFG_W-1:0] b;
        b                                = '0;
        b[CFG_ATS_EN_BIT]                = c.ats_en;
        b[CFG_TPH_EN_BIT]                = c.tph_en;
        b[CFG_TPH_ST_LSB +: 2]           = c.tph_st;
        b[CFG_MSIX_EN_BIT]               = c.msix_en;
        b[CFG_MSIX_MSK_BIT]              = c.msix_mask;
        b[CFG_BME_BIT]                   = c.bme;
        return b;
    endfunction

    // VFs all hang off PF0, so any VF update naming another PF is bogus.
    function automatic logic shdw_oob(input logic [1:0]  pf,
                                      input logic [10:0] vf,
                                      input logic        act,
                                      input int          num_pf,
                                      input int          num_vf);
        return (int'(pf) >= num_pf) ||
               (act && ((pf != 2'd0) || (int'(vf) >= num_vf)));
    endfunction

endpackage

// File: rtl/pcie_ctl_shdw_tracker_if.sv
// HIP control-shadow update bus plus the request-all handshake back to the HIP.
interface pcie_ctl_shdw_tracker_if;
    import ofs_fim_pcie_pkg::*;

    logic          ctl_shdw_update;
    logic [1:0]    ctl_shdw_pf_num;
    logic [10:0]   ctl_shdw_vf_num;
    logic          ctl_shdw_vf_active;
    t_ctl_shdw_cfg ctl_shdw_cfg;
    logic          ctl_shdw_req_all;

    modport master (
        output ctl_shdw_update, ctl_shdw_pf_num, ctl_shdw_vf_num,
               ctl_shdw_vf_active, ctl_shdw_cfg,
        input  ctl_shdw_req_all
    );

    modport slave (
        input  ctl_shdw_update, ctl_shdw_pf_num, ctl_shdw_vf_num,
               ctl_shdw_vf_active, ctl_shdw_cfg,
        output ctl_shdw_req_all
    );

endinterface

// File: rtl/pcie_ctl_shdw_scan_fsm.sv
// Request-all scan sequencer: REQ -> SCAN -> DONE with idle timeout and update count.
// Latency: transition taken at edge N shows on req_all/scan_done after edge N+1.
// No backpressure: samples an update strobe every cycle.
module pcie_ctl_shdw_scan_fsm
    import ofs_fim_pcie_pkg::*;
#(
    parameter int NUM_FN       = 6,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic avl_clk,
    input  logic avl_rst_n,
    input  logic upd_any,
    input  logic upd_inrange,
    input  logic rescan_req,
    output logic req_all,
    output logic scan_done
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int CNT_W  = $clog2(NUM_FN + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUM_FN);

    t_scan_state       state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              idle_expire;

    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q + IDLE_W'(1);
        cnt_d       = cnt_q;
        idle_expire = (idle_q == IDLE_LAST);
        unique case (state_q)
            SCAN_ST_REQ: begin
                // An update beats a coincident timeout.
                if (upd_any) begin
                    state_d = SCAN_ST_SCAN;
                    idle_d  = '0;
                    cnt_d   = CNT_W'(upd_inrange);
                end else if (idle_expire) begin
                    state_d = SCAN_ST_DONE;
                    idle_d  = '0;
                end
            end
            SCAN_ST_SCAN: begin
                if (upd_any) begin
                    idle_d = '0;
                    if (upd_inrange) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_FULL) state_d = SCAN_ST_DONE;
                    end
                end else if (idle_expire) begin
                    state_d = SCAN_ST_DONE;
                    idle_d  = '0;
                end
            end
            SCAN_ST_DONE: begin
                idle_d = '0;
                if (rescan_req) begin
                    state_d = SCAN_ST_REQ;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SCAN_ST_REQ;
                idle_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge avl_clk) begin
        if (!avl_rst_n) begin
            state_q   <= SCAN_ST_REQ;
            idle_q    <= '0;
            cnt_q     <= '0;
            req_all   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            cnt_q     <= cnt_d;
            req_all   <= (state_q == SCAN_ST_REQ);
            scan_done <= (state_q == SCAN_ST_DONE);
        end
    end

endmodule

// File: rtl/pcie_ctl_shdw_tracker.sv
// Captures HIP control-shadow updates into per-PF/VF state and emits change events.
// Latency: update sampled at edge N appears on cfg/vector/chg/oob outputs after edge N+1.
// No backpressure: one update per cycle accepted indefinitely; outputs are pulses/levels.
module pcie_ctl_shdw_tracker
    import ofs_fim_pcie_pkg::*;
#(
    parameter int NUM_PF       = 2,
    parameter int NUM_VF       = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                     avl_clk,
    input  logic                     avl_rst_n,
    pcie_ctl_shdw_tracker_if.slave   shdw,
    input  logic                     rescan_req,
    output logic [NUM_PF*CFG_W-1:0]  pf_cfg,
    output logic [NUM_VF-1:0]        vf_msix_en,
    output logic [NUM_VF-1:0]        vf_msix_mask,
    output logic [NUM_VF-1:0]        vf_bus_master_en,
    output logic                     chg_valid,
    output logic                     chg_vf_active,
    output logic [1:0]               chg_pf_num,
    output logic [10:0]              chg_vf_num,
    output logic [CFG_W-1:0]         chg_cfg,
    output logic                     scan_done,
    output logic [7:0]               oob_cnt
);

    t_ctl_shdw_cfg pf_cfg_q [NUM_PF];
    t_ctl_shdw_cfg vf_cfg_q [NUM_VF];

    logic          upd_q;
    logic [1:0]    upd_pf_q;
    logic [10:0]   upd_vf_q;
    logic          upd_act_q;
    t_ctl_shdw_cfg upd_cfg_q;

    logic          raw_inrange;
    logic          upd_oob_q;
    logic          upd_store;
    logic          cfg_differs;
    t_ctl_shdw_cfg old_cfg;

    // The scan FSM reacts to the raw strobe so its outputs line up with the
    // stored data, which goes through one input register first.
    assign raw_inrange = shdw.ctl_shdw_update &&
                         !shdw_oob(shdw.ctl_shdw_pf_num, shdw.ctl_shdw_vf_num,
                                   shdw.ctl_shdw_vf_active, NUM_PF, NUM_VF);

    pcie_ctl_shdw_scan_fsm #(
        .NUM_FN       (NUM_PF + NUM_VF),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_scan_fsm (
        .avl_clk     (avl_clk),
        .avl_rst_n   (avl_rst_n),
        .upd_any     (shdw.ctl_shdw_update),
        .upd_inrange (raw_inrange),
        .rescan_req  (rescan_req),
        .req_all     (shdw.ctl_shdw_req_all),
        .scan_done   (scan_done)
    );

    always_comb begin
        upd_oob_q = shdw_oob(upd_pf_q, upd_vf_q, upd_act_q, NUM_PF, NUM_VF);
        upd_store = upd_q && !upd_oob_q;
        old_cfg   = '0;
        for (int i = 0; i < NUM_PF; i++) begin
            if (!upd_act_q && int'(upd_pf_q) == i) old_cfg = pf_cfg_q[i];
        end
        for (int j = 0; j < NUM_VF; j++) begin
            if (upd_act_q && int'(upd_vf_q) == j) old_cfg = vf_cfg_q[j];
        end
        cfg_differs = (old_cfg != upd_cfg_q);
    end

    always_ff @(posedge avl_clk) begin
        if (!avl_rst_n) begin
            upd_q         <= 1'b0;
            upd_pf_q      <= '0;
            upd_vf_q      <= '0;
            upd_act_q     <= 1'b0;
            upd_cfg_q     <= '0;
            chg_valid     <= 1'b0;
            chg_vf_active <= 1'b0;
            chg_pf_num    <= '0;
            chg_vf_num    <= '0;
            chg_cfg       <= '0;
            oob_cnt       <= '0;
            for (int i = 0; i < NUM_PF; i++) pf_cfg_q[i] <= '0;
            for (int j = 0; j < NUM_VF; j++) vf_cfg_q[j] <= '0;
        end else begin
            upd_q     <= shdw.ctl_shdw_update;
            upd_pf_q  <= shdw.ctl_shdw_pf_num;
            upd_vf_q  <= shdw.ctl_shdw_vf_num;
            upd_act_q <= shdw.ctl_shdw_vf_active;
            upd_cfg_q <= shdw.ctl_shdw_cfg;

            chg_valid <= upd_store && cfg_differs;
            if (upd_store && cfg_differs) begin
                chg_vf_active <= upd_act_q;
                chg_pf_num    <= upd_pf_q;
                chg_vf_num    <= upd_vf_q;
                chg_cfg       <= cfg_to_bits(upd_cfg_q);
            end

            if (upd_q && upd_oob_q && oob_cnt != 8'hFF) oob_cnt <= oob_cnt + 8'd1;

            for (int i = 0; i < NUM_PF; i++) begin
                if (upd_store && !upd_act_q && int'(upd_pf_q) == i) pf_cfg_q[i] <= upd_cfg_q;
            end
            for (int j = 0; j < NUM_VF; j++) begin
                if (upd_store && upd_act_q && int'(upd_vf_q) == j) vf_cfg_q[j] <= upd_cfg_q;
            end
        end
    end

    for (genvar i = 0; i < NUM_PF; i++) begin : g_pf_out
        assign pf_cfg[CFG_W*i +: CFG_W] = cfg_to_bits(pf_cfg_q[i]);
    end

    for (genvar j = 0; j < NUM_VF; j++) begin : g_vf_out
        assign vf_msix_en[j]       = vf_cfg_q[j].msix_en;
        assign vf_msix_mask[j]     = vf_cfg_q[j].msix_mask;
        assign vf_bus_master_en[j] = vf_cfg_q[j].bme;
    end

endmodule
